// File: rtl/fp16_sub_seq_if.sv
// Operand/result handshake bundle for the half-precision subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface fp16_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        zero;
    logic        nan;
    logic        precisionLost;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, zero, nan, precisionLost
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, zero, nan, precisionLost
    );
endinterface

// File: rtl/fp16_sub_seq.sv
// fp16_sub_seq: IEEE-754 half-precision a - b, round toward zero, subnormals flushed to zero.
// Latency: 2 cycles for special operands, 4 + k for k normalising left shifts, 3 for an exact zero.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE, one op in flight.
module fp16_sub_seq #(
    parameter int SHIFT_GUARD = 3
) (
    input logic           clk,
    input logic           rst_n,
    fp16_sub_seq_if.slave io
);
    localparam int W = 11 + SHIFT_GUARD;

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, PACK, HOLD} state_t;

    state_t         state;
    logic           in_rdy_q, out_vld_q;
    logic [15:0]    res_q;
    logic           ovf_q, zero_q, nan_q, pl_q;
    logic [15:0]    op_a, op_b;
    logic           sx, sy;
    logic [5:0]     ex;
    logic [W-1:0]   x_sig, y_sig;
    logic [W:0]     sig;
    logic           sp_vld, sp_nan, sp_zero, sp_pl;
    logic [15:0]    sp_res;

    logic           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [15:0]    hi_op, lo_op;
    logic [4:0]     d;
    logic [W-1:0]   lo_sig, y_al;
    logic [2*W-1:0] y_ext;
    logic [W:0]     sum;
    logic           c_vld, c_nan, c_zero;
    logic [15:0]    c_res;

    // op_b already holds the negated subtrahend, so everything below is an addition a + op_b.
    always_comb begin
        a_nan  = (op_a[14:10] == 5'h1F) && (op_a[9:0] != 10'h0);
        b_nan  = (op_b[14:10] == 5'h1F) && (op_b[9:0] != 10'h0);
        a_inf  = (op_a[14:10] == 5'h1F) && (op_a[9:0] == 10'h0);
        b_inf  = (op_b[14:10] == 5'h1F) && (op_b[9:0] == 10'h0);
        a_zero = (op_a[14:10] == 5'h00);
        b_zero = (op_b[14:10] == 5'h00);
        a_big  = (op_a[14:0] >= op_b[14:0]);
        hi_op  = a_big ? op_a : op_b;
        lo_op  = a_big ? op_b : op_a;
        d      = hi_op[14:10] - lo_op[14:10];
        lo_sig = W'({1'b1, lo_op[9:0]}) << SHIFT_GUARD;
        y_ext  = {lo_sig, {W{1'b0}}} >> d;
        if (int'(d) >= W) begin
            y_al = {{(W-1){1'b0}}, 1'b1};
        end else begin
            y_al = y_ext[2*W-1:W] | {{(W-1){1'b0}}, |y_ext[W-1:0]};
        end

        c_vld  = 1'b1;
        c_nan  = 1'b0;
        c_zero = 1'b0;
        c_res  = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_inf && (op_a[15] != op_b[15]))) begin
            c_res = 16'h7E00;
            c_nan = 1'b1;
        end else if (a_inf) begin
            c_res = op_a;
        end else if (b_inf) begin
            c_res = op_b;
        end else if (a_zero && b_zero) begin
            c_zero = 1'b1;
        end else if (a_zero) begin
            c_res = op_b;
        end else if (b_zero) begin
            c_res = op_a;
        end else begin
            c_vld = 1'b0;
        end

        sum = (sx == sy) ? ({1'b0, x_sig} + {1'b0, y_sig}) : ({1'b0, x_sig} - {1'b0, y_sig});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            res_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            nan_q     <= 1'b0;
            pl_q      <= 1'b0;
            op_a      <= 16'h0000;
            op_b      <= 16'h0000;
            sx        <= 1'b0;
            sy        <= 1'b0;
            ex        <= 6'd0;
            x_sig     <= '0;
            y_sig     <= '0;
            sig       <= '0;
            sp_vld    <= 1'b0;
            sp_nan    <= 1'b0;
            sp_zero   <= 1'b0;
            sp_pl     <= 1'b0;
            sp_res    <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io.in_valid && in_rdy_q) begin
                        op_a     <= io.a;
                        op_b     <= {~io.b[15], io.b[14:0]};
                        in_rdy_q <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sp_vld  <= c_vld;
                    sp_nan  <= c_nan;
                    sp_zero <= c_zero;
                    sp_pl   <= 1'b0;
                    sp_res  <= c_res;
                    sx      <= hi_op[15];
                    sy      <= lo_op[15];
                    ex      <= {1'b0, hi_op[14:10]};
                    x_sig   <= W'({1'b1, hi_op[9:0]}) << SHIFT_GUARD;
                    y_sig   <= y_al;
                    state   <= c_vld ? PACK : ADDSUB;
                end
                ADDSUB: begin
                    sig <= sum;
                    if (sum == '0) begin
                        sp_vld  <= 1'b1;
                        sp_res  <= 16'h0000;
                        sp_zero <= 1'b1;
                        state   <= PACK;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (sig[W]) begin
                        sig   <= {1'b0, sig[W:2], sig[1] | sig[0]};
                        ex    <= ex + 6'd1;
                        state <= PACK;
                    end else if (sig[W-1]) begin
                        state <= PACK;
                    end else if (ex == 6'd1) begin
                        // One more shift would land in the subnormal range, which is flushed.
                        sp_vld  <= 1'b1;
                        sp_res  <= {sx, 15'h0000};
                        sp_zero <= 1'b1;
                        sp_pl   <= 1'b1;
                        state   <= PACK;
                    end else begin
                        sig <= sig << 1;
                        ex  <= ex - 6'd1;
                    end
                end
                PACK: begin
                    if (sp_vld) begin
                        res_q  <= sp_res;
                        ovf_q  <= 1'b0;
                        zero_q <= sp_zero;
                        nan_q  <= sp_nan;
                        pl_q   <= sp_pl;
                    end else begin
                        zero_q <= 1'b0;
                        nan_q  <= 1'b0;
                        pl_q   <= |sig[SHIFT_GUARD-1:0];
                        if (ex >= 6'd31) begin
                            res_q <= {sx, 5'h1F, 10'h000};
                            ovf_q <= 1'b1;
                        end else begin
                            res_q <= {sx, ex[4:0], sig[W-2:SHIFT_GUARD]};
                            ovf_q <= 1'b0;
                        end
                    end
                    out_vld_q <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (io.out_ready) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready      = in_rdy_q;
    assign io.out_valid     = out_vld_q;
    assign io.result        = res_q;
    assign io.overflow      = ovf_q;
    assign io.zero          = zero_q;
    assign io.nan           = nan_q;
    assign io.precisionLost = pl_q;
endmodule
